// File: rtl/cdc_chan_arb_pkg.sv
// Shared definitions for the toggle-handshake CDC channel arbiter and its ack synchronizer.
package cdc_chan_arb_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LAUNCH   = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// Two-flop synchronizer plus history register turning a returning ack toggle into a one-cycle event.
module cdc_ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic ack_toggle,
    output logic ack_evt
);

    logic sync1, sync2, hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= ack_toggle;
            sync2 <= sync1;
            // hist follows sync2 unconditionally so a stale edge is consumed wherever the FSM is
            hist  <= sync2;
        end
    end

    assign ack_evt = sync2 ^ hist;

endmodule

// File: rtl/cdc_chan_arb.sv
// Round-robin arbiter sharing one toggle-handshake CDC channel between N source-domain requesters.
module cdc_chan_arb
    import cdc_chan_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   data_in,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic [W-1:0]     xfer_data,
    output logic [IDW-1:0]   xfer_id,
    output logic             xfer_toggle,
    input  logic             ack_toggle,
    output logic             busy,
    output logic             timeout_err
);

    localparam int            CW       = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;
    logic           ack_evt;
    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] next_ptr;

    cdc_ack_sync u_ack_sync (
        .clk        (clk),
        .rst        (rst),
        .ack_toggle (ack_toggle),
        .ack_evt    (ack_evt)
    );

    // First asserted request at or above ptr, wrapping N-1 -> 0
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    assign next_ptr = (xfer_id == IDW'(N - 1)) ? '0 : xfer_id + IDW'(1);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            gnt         <= '0;
            done        <= '0;
            xfer_data   <= '0;
            xfer_id     <= '0;
            xfer_toggle <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gnt       <= N'(1) << winner;
                        xfer_data <= data_in[int'(winner)*W +: W];
                        xfer_id   <= winner;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    // data has been stable for a full cycle before the toggle flips
                    xfer_toggle <= ~xfer_toggle;
                    cnt         <= '0;
                    state       <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_evt) begin
                        done  <= N'(1) << xfer_id;
                        ptr   <= next_ptr;
                        state <= ST_IDLE;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        ptr         <= next_ptr;
                        state       <= ST_IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_chan_arb.sv
// Directed bench for cdc_chan_arb: arbitration order, ack latency, timeout and reset recovery.
module tb_cdc_chan_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt, done;
    logic [7:0]  xfer_data;
    logic [1:0]  xfer_id;
    logic        xfer_toggle;
    logic        ack_toggle;
    logic        busy, timeout_err;
    logic        exp_tog;

    int checks = 0;
    int errors = 0;

    cdc_chan_arb #(.N(4), .W(8), .IDW(2), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data_in     (data_in),
        .gnt         (gnt),
        .done        (done),
        .xfer_data   (xfer_data),
        .xfer_id     (xfer_id),
        .xfer_toggle (xfer_toggle),
        .ack_toggle  (ack_toggle),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = '0;
        ack_toggle = 1'b0;
        exp_tog    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Wait for the grant, check capture and launch, ack after dly cycles, expect done 3 cycles later
    task automatic do_xfer(input int id, input logic [7:0] d, input int dly);
        int n;
        n = 0;
        tick();
        while (gnt == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("gnt", gnt, 32'(1 << id));
        chk("xfer_data", xfer_data, d);
        chk("xfer_id", xfer_id, id);
        chk("tog_before_launch", xfer_toggle, exp_tog);
        tick();
        exp_tog = ~exp_tog;
        chk("tog_launch", xfer_toggle, exp_tog);
        chk("gnt_pulse", gnt, 0);
        repeat (dly) begin
            tick();
            chk("done_early", done, 0);
        end
        ack_toggle = ~ack_toggle;
        repeat (2) begin
            tick();
            chk("done_early", done, 0);
        end
        tick();
        chk("done", done, 32'(1 << id));
        chk("busy_after_done", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_onehot", 32'($onehot0(gnt)), 1);
            chk("done_onehot", 32'($onehot0(done)), 1);
        end
    end

    initial begin
        data_in = 32'h0000_00A5;
        do_reset();

        // idle after reset
        repeat (10) tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_xfer_data", xfer_data, 0);
        chk("rst_xfer_id", xfer_id, 0);
        chk("rst_toggle", xfer_toggle, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);

        // single transfer, ack 4 cycles after launch
        req = 4'b0001;
        do_xfer(0, 8'hA5, 4);
        req = 4'b0;
        tick();
        chk("done_pulse", done, 0);

        // all requesting: round robin from pointer 0
        do_reset();
        data_in = 32'h1312_1110;
        req = 4'b1111;
        do_xfer(0, 8'h10, 2);
        do_xfer(1, 8'h11, 2);
        do_xfer(2, 8'h12, 2);
        do_xfer(3, 8'h13, 2);
        do_xfer(0, 8'h10, 2);
        req = 4'b0;

        // timeout on requester 2 (pointer is 1)
        req = 4'b0100;
        tick();
        chk("to_gnt", gnt, 4'b0100);
        chk("to_xfer_id", xfer_id, 2);
        req = 4'b0;
        tick();
        exp_tog = ~exp_tog;
        chk("to_launch", xfer_toggle, exp_tog);
        repeat (15) begin
            tick();
            chk("to_done", done, 0);
            chk("to_early", timeout_err, 0);
            chk("to_busy", busy, 1);
        end
        tick();
        chk("to_err", timeout_err, 1);
        chk("to_no_done", done, 0);
        chk("to_idle", busy, 0);

        // late ack is swallowed; a fresh ack completes requester 0
        repeat (5) tick();
        ack_toggle = ~ack_toggle;
        repeat (4) begin
            tick();
            chk("late_ack", done, 0);
        end
        req = 4'b0001;
        do_xfer(0, 8'h10, 8);
        req = 4'b0;
        chk("err_sticky", timeout_err, 1);

        // ack event in the last counting cycle wins over the timeout
        do_reset();
        req = 4'b0010;
        do_xfer(1, 8'h11, 13);
        req = 4'b0;
        chk("race_no_err", timeout_err, 0);
        tick();
        chk("race_no_err2", timeout_err, 0);
        chk("race_done_pulse", done, 0);

        // reset in WAIT_ACK clears toggle and pointer
        req = 4'b0100;
        do_xfer(2, 8'h12, 2);
        req = 4'b0100;
        tick();
        chk("mid_gnt", gnt, 4'b0100);
        req = 4'b0;
        tick();
        chk("mid_toggle", xfer_toggle, 1);
        repeat (3) tick();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        ack_toggle = 1'b0;
        tick();
        chk("mid_rst_toggle", xfer_toggle, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_xfer_id", xfer_id, 0);
        rst = 1'b0;
        exp_tog = 1'b0;
        req = 4'b1010;
        do_xfer(1, 8'h11, 2);
        req = 4'b0;

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
